// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy flags, over/underflow pulses and optional FWFT read
module sync_fifo_param #(
  parameter int D_WIDTH   = 8,
  parameter int D_DEPTH   = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_en,
  input  logic [D_WIDTH-1:0]         w_data,
  input  logic                       r_en,
  output logic [D_WIDTH-1:0]         r_data,
  output logic                       r_valid,
  output logic                       isFull,
  output logic                       isEmpty,
  output logic                       almostFull,
  output logic                       almostEmpty,
  output logic [$clog2(D_DEPTH):0]   count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int AW = $clog2(D_DEPTH);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] FULL = D_DEPTH[AW:0];
  localparam logic [AW:0] AF = AF_THRESH[AW:0];
  localparam logic [AW:0] AE = AE_THRESH[AW:0];
  logic [D_WIDTH-1:0] mem [D_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count_nxt;
  logic rd_acc, wr_acc;
  always_comb begin
    rd_acc    = r_en & ~isEmpty;
    wr_acc    = w_en & (~isFull | rd_acc);
    count_nxt = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      isEmpty     <= 1'b1;
      isFull      <= 1'b0;
      almostEmpty <= 1'b1;
      almostFull  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      count       <= count_nxt;
      isEmpty     <= count_nxt == '0;
      isFull      <= count_nxt == FULL;
      almostEmpty <= count_nxt <= AE;
      almostFull  <= count_nxt >= AF;
      overflow    <= w_en & ~wr_acc;
      underflow   <= r_en & ~rd_acc;
    end
  always_ff @(posedge clk)
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= w_data;
  if (FWFT != 0) begin : g_fwft
    always_comb begin
      r_valid = ~isEmpty;
      r_data  = isEmpty ? '0 : mem[rd_ptr[AW-1:0]];
    end
  end else begin : g_reg
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_valid <= rd_acc;
        if (rd_acc) r_data <= mem[rd_ptr[AW-1:0]];
      end
  end
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed scoreboard bench for registered-read and FWFT FIFO instances
module tb_sync_fifo_param;
  logic clk = 0, rst = 1;
  logic w_en = 0, r_en = 0, w_en1 = 0, r_en1 = 0;
  logic [7:0] w_data = 0;
  logic [7:0] r_data, r_data1;
  logic r_valid, is_full, is_empty, a_full, a_empty, ovf, unf;
  logic r_valid1, is_full1, is_empty1, a_full1, a_empty1, ovf1, unf1;
  logic [3:0] count, count1;
  int vectors = 0, miscompares = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  sync_fifo_param #(.FWFT(0)) u0 (
    .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data), .r_en(r_en),
    .r_data(r_data), .r_valid(r_valid), .isFull(is_full), .isEmpty(is_empty),
    .almostFull(a_full), .almostEmpty(a_empty), .count(count),
    .overflow(ovf), .underflow(unf));

  sync_fifo_param #(.FWFT(1)) u1 (
    .clk(clk), .rst(rst), .w_en(w_en1), .w_data(w_data), .r_en(r_en1),
    .r_data(r_data1), .r_valid(r_valid1), .isFull(is_full1), .isEmpty(is_empty1),
    .almostFull(a_full1), .almostEmpty(a_empty1), .count(count1),
    .overflow(ovf1), .underflow(unf1));

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // registered-read data is checked here whenever the DUT flags a valid word
  always @(negedge clk)
    if (!rst && r_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_data: got %0h with no word expected", r_data);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (r_data !== e) begin
          miscompares++;
          $display("FAIL rd_data: got %0h expected %0h", r_data, e);
        end
      end
    end

  task automatic cyc(input logic we, input logic [7:0] wd, input logic re,
                     input logic push, input logic [7:0] exp);
    w_en = we; w_data = wd; r_en = re;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    w_en = 0; r_en = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_count", count, 0);
    check("rst_empty", is_empty, 1);
    check("rst_aempty", a_empty, 1);
    check("rst_valid", r_valid, 0);
    // 1: reset while writes are streaming in
    for (int i = 0; i < 3; i++) cyc(1, 8'hE0 + 8'(i), 0, 0, 0);
    check("pre_rst_count", count, 3);
    w_en = 1; rst = 1;
    #1;
    check("async_rst_count", count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0; w_en = 0;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", is_empty, 1);
    check("mid_rst_aempty", a_empty, 1);
    check("mid_rst_valid", r_valid, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_unf", unf, 0);
    cyc(1, 8'h77, 0, 0, 0);
    cyc(0, 0, 1, 1, 8'h77);
    // 2: fill and drain
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 8'(i), 0, 0, 0);
      check("fill_count", count, i);
      check("fill_afull", a_full, i >= 6);
      check("fill_aempty", a_empty, i <= 2);
    end
    check("fill_full", is_full, 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, 1, 8'(i));
      check("drain_count", count, 8 - i);
    end
    check("drain_empty", is_empty, 1);
    check("drain_full", is_full, 0);
    // 3: overflow and underflow pulses
    for (int i = 0; i < 8; i++) cyc(1, 8'h20 + 8'(i), 0, 0, 0);
    cyc(1, 8'h99, 0, 0, 0);
    check("ovf_pulse", ovf, 1);
    check("ovf_count", count, 8);
    cyc(0, 0, 0, 0, 0);
    check("ovf_clear", ovf, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 8'h20 + 8'(i));
    cyc(0, 0, 1, 0, 0);
    check("unf_pulse", unf, 1);
    check("unf_valid", r_valid, 0);
    cyc(0, 0, 0, 0, 0);
    check("unf_clear", unf, 0);
    // 4: simultaneous read/write at full and at empty
    for (int i = 0; i < 8; i++) cyc(1, 8'h30 + 8'(i), 0, 0, 0);
    cyc(1, 8'hAA, 1, 1, 8'h30);
    check("full_both_count", count, 8);
    check("full_both_ovf", ovf, 0);
    for (int i = 1; i < 8; i++) cyc(0, 0, 1, 1, 8'h30 + 8'(i));
    cyc(0, 0, 1, 1, 8'hAA);
    check("aa_last_empty", is_empty, 1);
    cyc(1, 8'hBB, 1, 0, 0);
    check("empty_both_count", count, 1);
    check("empty_both_unf", unf, 1);
    cyc(0, 0, 1, 1, 8'hBB);
    // 5: interleaved traffic across the pointer wrap
    cyc(1, 8'h10, 0, 0, 0);
    for (int i = 1; i < 20; i++) begin
      cyc(1, 8'h10 + 8'(i), 1, 1, 8'h10 + 8'(i - 1));
      check("wrap_count", count, 1);
    end
    cyc(0, 0, 1, 1, 8'h10 + 8'd19);
    check("wrap_empty", is_empty, 1);
    // 6: first-word-fall-through instance
    check("fwft_idle_valid", r_valid1, 0);
    w_en1 = 1; w_data = 8'h55;
    @(posedge clk); #1 w_en1 = 0;
    check("fwft_valid", r_valid1, 1);
    check("fwft_data", r_data1, 8'h55);
    @(posedge clk); #1;
    check("fwft_hold", r_data1, 8'h55);
    w_en1 = 1; w_data = 8'h66;
    @(posedge clk); #1 w_data = 8'h67;
    @(posedge clk); #1 w_en1 = 0; r_en1 = 1;
    @(posedge clk); #1;
    check("fwft_pop1", r_data1, 8'h66);
    @(posedge clk); #1;
    check("fwft_pop2", r_data1, 8'h67);
    @(posedge clk); #1 r_en1 = 0;
    check("fwft_empty", is_empty1, 1);
    check("fwft_empty_valid", r_valid1, 0);
    repeat (2) @(posedge clk);
    check("scoreboard_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
